// File: rtl/brush_painter.sv
// Expands one stamp or fill command into a raster-ordered stream of single-pixel
// GPU write strobes, clipped to the 64x64 panel and spaced by WR_GAP idle cycles.
module brush_painter #(
  parameter int WR_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_cmd,
  input  logic [5:0] in_x,
  input  logic [5:0] in_y,
  input  logic [2:0] in_size,
  input  logic [7:0] in_color,
  input  logic       in_layer,
  output logic       out_ready,
  output logic       out_write,
  output logic [7:0] out_px_data,
  output logic [5:0] out_column,
  output logic [5:0] out_row,
  output logic       out_image_overlay,
  output logic       out_image_palette,
  output logic       out_done
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [5:0] col_q, col_d;
  logic [5:0] row_q, row_d;
  logic [5:0] x_start_q, x_start_d;
  logic [5:0] x_end_q, x_end_d;
  logic [5:0] y_end_q, y_end_d;
  logic [7:0] color_q, color_d;
  logic       layer_q, layer_d;
  logic [3:0] gap_q, gap_d;

  logic [6:0] x_sum, y_sum;
  logic       at_end;
  logic       advance;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x_start_d = x_start_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    color_d   = color_q;
    layer_d   = layer_q;
    gap_d     = gap_q;
    advance   = 1'b0;

    // 7-bit sums so a brush hanging off the panel clips instead of wrapping.
    x_sum  = {1'b0, in_x} + {4'b0, in_size};
    y_sum  = {1'b0, in_y} + {4'b0, in_size};
    at_end = (col_q == x_end_q) && (row_q == y_end_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          color_d = in_color;
          layer_d = in_layer;
          state_d = WRITE;
          if (in_cmd) begin
            col_d     = 6'd0;
            row_d     = 6'd0;
            x_start_d = 6'd0;
            x_end_d   = 6'd63;
            y_end_d   = 6'd63;
          end else begin
            col_d     = in_x;
            row_d     = in_y;
            x_start_d = in_x;
            x_end_d   = x_sum[6] ? 6'd63 : x_sum[5:0];
            y_end_d   = y_sum[6] ? 6'd63 : y_sum[5:0];
          end
        end
      end
      WRITE: begin
        if (at_end) begin
          state_d = DONE;
        end else if (WR_GAP == 0) begin
          advance = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = 4'd0;
        end
      end
      GAP: begin
        // The coordinate only moves when leaving GAP, so it holds the last
        // written pixel for the whole idle stretch.
        if (gap_q == GAP_LAST) begin
          state_d = WRITE;
          advance = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (col_q == x_end_q) begin
        col_d = x_start_q;
        row_d = row_q + 6'd1;
      end else begin
        col_d = col_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= 6'd0;
      row_q     <= 6'd0;
      x_start_q <= 6'd0;
      x_end_q   <= 6'd0;
      y_end_q   <= 6'd0;
      color_q   <= 8'd0;
      layer_q   <= 1'b0;
      gap_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x_start_q <= x_start_d;
      x_end_q   <= x_end_d;
      y_end_q   <= y_end_d;
      color_q   <= color_d;
      layer_q   <= layer_d;
      gap_q     <= gap_d;
    end
  end

  assign out_ready         = (state_q == IDLE);
  assign out_write         = (state_q == WRITE);
  assign out_done          = (state_q == DONE);
  assign out_px_data       = color_q;
  assign out_column        = col_q;
  assign out_row           = row_q;
  assign out_image_overlay = layer_q;
  assign out_image_palette = 1'b0;

endmodule

// File: doc/brush_painter.md
# brush_painter

Drawing engine that sits directly upstream of the retro_paint GPU write port. It accepts one paint command at a time: a square brush stamp or a full-layer fill. It expands the command into a raster-ordered stream of single-pixel write strobes (`write`, `px_data`, `column`, `row`, `image_palette`, `image_overlay`) that the GPU's command decoder consumes. It clips to the 64x64 panel, spaces writes by a programmable gap, and signals completion.

## Interface
Parameters:
- `WR_GAP`, default 1: idle cycles inserted between consecutive write strobes. Legal range is 0..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command strobe; accepted only when `out_ready`=1.
- `in_cmd`  in  1  0 = stamp, 1 = fill whole layer.
- `in_x`  in  6  stamp left column (0..63).
- `in_y`  in  6  stamp top row (0..63).
- `in_size`  in  3  brush edge length minus 1; edge length is 1..8.
- `in_color`  in  8  pixel value written.
- `in_layer`  in  1  0 = image VRAM, 1 = overlay VRAM.
- `out_ready`  out  1  high only in IDLE.
- `out_write`  out  1  one-cycle write strobe to the GPU.
- `out_px_data`  out  8  latched color.
- `out_column`  out  6  current pixel column.
- `out_row`  out  6  current pixel row.
- `out_image_overlay`  out  1  latched `in_layer`.
- `out_image_palette`  out  1  constant 0; the block never selects the palette ROM.
- `out_done`  out  1  one-cycle pulse after the last write of a command.

## Operation
- States are IDLE, WRITE, GAP and DONE. Reset enters IDLE.
- IDLE:
  - `out_ready`=1.
  - On `in_valid`=1, latch the command and go to WRITE.
- Command latching:
  - `in_color` and `in_layer` are latched.
  - Stamp: start = (`in_x`, `in_y`). Ends are computed at 7 bits: x_end = min(`in_x` + `in_size`, 63), y_end = min(`in_y` + `in_size`, 63). No wrap-around.
  - Fill: start = (0,0), end = (63,63). `in_x`, `in_y` and `in_size` are ignored.
- WRITE:
  - `out_write`=1 for exactly one cycle, with `out_column`/`out_row` = current coordinate.
  - If the coordinate equals (x_end, y_end), go to DONE.
  - Otherwise advance the coordinate. The column increments first; when column = x_end, column reloads the start column and row increments.
  - Then go to GAP if `WR_GAP`>0, else stay in WRITE.
- GAP: count `WR_GAP` cycles with `out_write`=0, then return to WRITE.
- DONE: `out_done`=1 for one cycle, then go to IDLE.
- Pixel count: N = (x_end − x_start + 1) × (y_end − y_start + 1). Fill gives N = 4096.
- `in_valid` while `out_ready`=0 is ignored. Commands are not queued.
- `out_px_data`, `out_column`, `out_row` and `out_image_overlay` are registers. They hold their last value outside WRITE.
- Reset:
  - `rst` in any state, including mid-command, returns to IDLE on that edge. No further strobes are issued.
  - Reset values: `out_write`=0, `out_done`=0, `out_ready`=1, `out_px_data`=0, `out_column`=0, `out_row`=0, `out_image_overlay`=0, `out_image_palette`=0.

## Timing
- Let edge 0 be the edge where `in_valid` & `out_ready` is sampled high.
- `out_ready` falls in cycle 1 (the cycle after edge 0).
- Write i (i = 0..N−1) is asserted in cycle 1 + i×(`WR_GAP`+1).
- `out_done` is asserted in cycle 2 + (N−1)×(`WR_GAP`+1).
- `out_ready`=1 in the following cycle. A new command may be accepted on that cycle's closing edge.
- Strobes never occur in consecutive cycles unless `WR_GAP`=0.
- `out_write` and `out_done` are never high in the same cycle.
- Throughput for fill with `WR_GAP`=1: 8191 cycles from first strobe to last.

## Test plan
- Reset, then 1x1 stamp at (5,7), color 0xA3, layer 0, `WR_GAP`=1:
  - exactly one strobe in cycle 1, at col 5, row 7, data 0xA3, overlay 0;
  - `out_done` in cycle 2;
  - `out_ready` back in cycle 3.
- Stamp at (10,20), `in_size`=3, layer 1:
  - 16 strobes, spaced 2 cycles apart, ordered (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23);
  - overlay=1 on all;
  - `out_done` 1 cycle after the last strobe.
- Clipping: stamp at (62,62), `in_size`=7 → 4 strobes, at (62,62),(63,62),(62,63),(63,63). Nothing wraps to column or row 0.
- Fill, color 0x00, `WR_GAP`=0:
  - 4096 strobes in 4096 consecutive cycles, (0,0) through (63,63);
  - `out_done` in cycle 4097.
- Busy rejection: issue a stamp; pulse `in_valid` with a different command at the 3rd strobe → ignored, original strobe stream unchanged.
- Mid-command reset: assert `rst` during the 5th strobe of a fill:
  - the next cycle shows `out_write`=0, `out_ready`=1, all outputs 0;
  - no `out_done`;
  - a fresh 1x1 command then behaves as in the first scenario.
